// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Fetch/LSU arbiter and sequencer for a single-port memory
//            controller. Optional starvation guard: MEM_ARB_STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_ADDR      = 32'h30000,
  parameter int                    STARVE_LIMIT = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  if_req_in,
  input  logic [ADDR_WIDTH-1:0] if_addr_in,
  input  logic                  if_flush_in,
  output logic                  if_done_out,
  output logic [DATA_WIDTH-1:0] if_data_out,
  input  logic                  ls_req_in,
  input  logic                  ls_we_in,
  input  logic [ADDR_WIDTH-1:0] ls_addr_in,
  input  logic [DATA_WIDTH-1:0] ls_wdata_in,
  input  logic [1:0]            ls_size_in,
  output logic                  ls_done_out,
  output logic [DATA_WIDTH-1:0] ls_rdata_out,
  output logic                  mc_en_out,
  output logic                  mc_we_out,
  output logic [ADDR_WIDTH-1:0] mc_addr_out,
  output logic [DATA_WIDTH-1:0] mc_wdata_out,
  output logic [1:0]            mc_size_out,
  input  logic                  mc_done_in,
  input  logic [DATA_WIDTH-1:0] mc_rdata_in,
  input  logic                  io_buffer_full_in,
  output logic                  busy_out
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_IO_HOLD = 3'd1;
  localparam logic [2:0] S_BUSY_IF = 3'd2;
  localparam logic [2:0] S_BUSY_LS = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       kill;
  logic       if_ok;
  logic       grant_ls;
  logic       grant_if;
  logic       io_block;

  // A fetch that is being flushed in the same cycle is never worth starting.
  assign if_ok    = if_req_in & ~if_flush_in;
  assign io_block = ls_we_in & (ls_addr_in == IO_ADDR) & io_buffer_full_in;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [2:0] streak;
  logic       force_if;

  assign force_if = (streak == LIMIT) & ls_req_in & if_ok;
  assign grant_ls = ls_req_in & ~force_if;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      streak <= '0;
    end else if (rdy_in) begin
      if (!if_req_in) begin
        streak <= '0;
      end else if (state == S_IDLE) begin
        if (grant_ls) begin
          if (streak != 3'd7) streak <= streak + 3'd1;
        end else if (grant_if) begin
          streak <= '0;
        end
      end
    end
  end
`else
  assign grant_ls = ls_req_in;
`endif

  assign grant_if = if_ok & ~grant_ls;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= S_IDLE;
    end else if (rdy_in) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (grant_ls)      state_nxt = io_block ? S_IO_HOLD : S_BUSY_LS;
        else if (grant_if) state_nxt = S_BUSY_IF;
      end
      S_IO_HOLD: if (!io_buffer_full_in) state_nxt = S_BUSY_LS;
      S_BUSY_IF,
      S_BUSY_LS: if (mc_done_in) state_nxt = S_RELEASE;
      S_RELEASE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mc_en_out = (state == S_BUSY_IF) || (state == S_BUSY_LS);
    busy_out  = (state != S_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mc_we_out    <= 1'b0;
      mc_addr_out  <= '0;
      mc_wdata_out <= '0;
      mc_size_out  <= 2'd0;
      if_done_out  <= 1'b0;
      if_data_out  <= '0;
      ls_done_out  <= 1'b0;
      ls_rdata_out <= '0;
      kill         <= 1'b0;
    end else if (rdy_in) begin
      if_done_out <= 1'b0;
      ls_done_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_ls) begin
            mc_we_out    <= ls_we_in;
            mc_addr_out  <= ls_addr_in;
            mc_wdata_out <= ls_wdata_in;
            mc_size_out  <= ls_size_in;
          end else if (grant_if) begin
            mc_we_out    <= 1'b0;
            mc_addr_out  <= if_addr_in;
            mc_wdata_out <= '0;
            mc_size_out  <= 2'd2;
          end
        end
        S_BUSY_IF: begin
          if (if_flush_in) kill <= 1'b1;
          // The controller cannot abort, so a killed fetch completes silently.
          if (mc_done_in && !kill && !if_flush_in) begin
            if_done_out <= 1'b1;
            if_data_out <= mc_rdata_in;
          end
        end
        S_BUSY_LS: begin
          if (mc_done_in) begin
            ls_done_out  <= 1'b1;
            ls_rdata_out <= mc_rdata_in;
          end
        end
        S_RELEASE: kill <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer placed in front of the single-port memory controller. It shares the controller between the instruction fetcher and the load/store unit. It latches one request at a time and drives the controller's enable/address/data lines until the transaction completes. It then returns the result with a one-cycle done pulse and releases the controller for one cycle so the controller sees its enable drop. Stores to the I/O port are held back while the external UART buffer is full.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- IO_ADDR, 32'h30000, memory-mapped I/O port address
- STARVE_LIMIT, 4, consecutive LSU grants tolerated while fetch waits (only with guard enabled)
---
- clk_in  input  1  clock, rising edge
- rst_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  global enable; low freezes all state and outputs
- if_req_in  input  1  fetch request, held until if_done_out
- if_addr_in  input  ADDR_WIDTH  fetch word address
- if_flush_in  input  1  discard in-flight or pending fetch
- if_done_out  output  1  one-cycle fetch completion pulse
- if_data_out  output  DATA_WIDTH  fetched word, valid with if_done_out
- ls_req_in  input  1  LSU request, held until ls_done_out
- ls_we_in  input  1  1 = store, 0 = load
- ls_addr_in  input  ADDR_WIDTH  LSU byte address
- ls_wdata_in  input  DATA_WIDTH  store data
- ls_size_in  input  2  0 = byte, 1 = half, 2 = word
- ls_done_out  output  1  one-cycle LSU completion pulse
- ls_rdata_out  output  DATA_WIDTH  load data, valid with ls_done_out
- mc_en_out  output  1  controller enable, held high for the whole transaction
- mc_we_out, mc_addr_out, mc_wdata_out, mc_size_out  output  1/ADDR/DATA/2  latched transaction fields
- mc_done_in  input  1  controller completion
- mc_rdata_in  input  DATA_WIDTH  controller read data
- io_buffer_full_in  input  1  UART buffer full
- busy_out  output  1  high in every state except IDLE

## Operation
- States: IDLE, IO_HOLD, BUSY_IF, BUSY_LS, RELEASE.
- **IDLE** (arbitration):
  - ls_req_in has priority over if_req_in.
  - An if_req_in that coincides with if_flush_in is not granted.
  - The winning request's fields are latched into holding registers.
  - Fetch grant: mc_size_out = 2, mc_we_out = 0.
  - LSU store with address == IO_ADDR while io_buffer_full_in = 1 goes to IO_HOLD. All other LSU grants go to BUSY_LS, fetch grants to BUSY_IF.
- **IO_HOLD**: mc_en_out stays low. Moves to BUSY_LS in the first cycle io_buffer_full_in = 0. Loads from IO_ADDR are never held.
- **BUSY_IF / BUSY_LS**:
  - mc_en_out = 1; fields stay constant.
  - On mc_done_in: capture mc_rdata_in into if_data_out or ls_rdata_out, pulse the matching done, move to RELEASE.
  - Data outputs hold their value until the next completion.
- **RELEASE**: mc_en_out = 0. All requests are ignored. Next state is IDLE.
- **Flush**:
  - if_flush_in during BUSY_IF sets a kill flag. The transaction still runs to mc_done_in (the controller cannot abort), but if_done_out is suppressed and if_data_out is not updated.
  - The kill flag clears in RELEASE.
- Simultaneous mc_done_in and if_flush_in in BUSY_IF: the done is suppressed.
- No alignment checks; sizes pass through unchanged.
- Reset: state IDLE; every output 0; holding registers, kill flag and streak counter cleared. Reset during a transaction abandons it; no done is issued.

## Timing
- Request sampled in IDLE at cycle T: mc_en_out high from T+1.
- mc_done_in in cycle D:
  - done pulse and data at D+1, with mc_en_out low at D+1 (RELEASE).
  - IDLE at D+2; the earliest next mc_en_out is D+3.
- Requesters drop req in the cycle after they see done, so a completed request is never re-granted.
- IO_HOLD adds one cycle per cycle of io_buffer_full_in = 1.
- rdy_in = 0 freezes everything. A mc_done_in arriving while rdy_in = 0 is ignored; the controller holds done until accepted.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A 3-bit streak counter increments on each LSU grant made while if_req_in = 1.
  - It clears on an IF grant or whenever if_req_in = 0.
  - In IDLE, if streak == STARVE_LIMIT and both requests are present, the fetch wins.
- Undefined: strict LSU priority and no counter logic. A continuously requesting LSU may starve fetch indefinitely.

## Test plan
- **Basic fetch**: reset, if_req_in = 1, if_addr_in = 0x100; mc_done_in 5 cycles after mc_en_out with mc_rdata_in = 0x00A00093. Expect if_done_out a single cycle with if_data_out = 0x00A00093, and mc_en_out low that same cycle.
- **Simultaneous requests**: if_req_in and ls_req_in (load 0x2000) in the same cycle. Expect mc_addr_out = 0x2000 first, then fetch mc_en_out three cycles after ls_done_out's mc_done_in.
- **I/O store hold**: store to 0x30000 data 0x41 with io_buffer_full_in = 1 for 6 cycles. Expect mc_en_out low for 6 cycles, then high with mc_wdata_out = 0x41.
- **Flush in flight**: if_flush_in pulse mid BUSY_IF. Expect no if_done_out, if_data_out unchanged, busy_out low two cycles after mc_done_in.
- **Starvation guard**: with guard enabled and STARVE_LIMIT = 4, LSU and fetch requests both held high. Expect the 5th grant to be fetch. With guard disabled, expect all grants to be LSU.
- **Reset mid-transaction**: rst_in low during BUSY_LS. Expect all outputs 0 immediately and no ls_done_out after release.
